// File: rtl/load_store_unit.sv
// MEM-stage load/store controller: word accesses pass through, sub-word stores use a
// two-cycle read-modify-write, loads are lane-extracted and extended, illegal accesses flagged.
module load_store_unit #(
  parameter int unsigned MEM_SIZE_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        err,
  output logic        Mem_read,
  output logic        Mem_write,
  output logic [31:0] Mem_address,
  output logic [31:0] Write_data,
  input  logic [31:0] Read_Data
);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state, state_next;
  logic        illegal, accept, acc_ok, is_access;
  logic        do_load, do_wstore, do_sub, do_err;
  logic [31:0] word_addr, load_data, merged;
  logic [31:0] rmw_addr_p1, rmw_data_p1;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    if (size == 2'b00)
      m[{lane, 3'b000} +: 8] = wdata[7:0];
    else if (lane[1])
      m[31:16] = wdata[15:0];
    else
      m[15:0] = wdata[15:0];
    return m;
  endfunction

  always_comb begin
    illegal = 1'b0;
    if (req_read && req_write)                       illegal = 1'b1;
    if (req_size == 2'b11)                           illegal = 1'b1;
    if (req_size == 2'b01 && req_addr[0])            illegal = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) illegal = 1'b1;
    if (req_addr >= 32'(MEM_SIZE_BYTES))             illegal = 1'b1;
  end

  // Gating with reset makes the memory strobes drop the instant reset asserts.
  assign accept    = reset && (state == IDLE) && req_valid;
  assign is_access = accept && (req_read || req_write);
  assign acc_ok    = is_access && !illegal;
  assign do_err    = is_access && illegal;
  assign do_load   = acc_ok && req_read;
  assign do_wstore = acc_ok && req_write && (req_size == 2'b10);
  assign do_sub    = acc_ok && req_write && (req_size != 2'b10);

  assign word_addr = {req_addr[31:2], 2'b00};
  assign load_data = extend_load(Read_Data, req_addr[1:0], req_size, req_signed);
  assign merged    = merge_lane(Read_Data, req_addr[1:0], req_size, req_wdata);
  assign stall     = (state == RMW_WR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (do_sub) state_next = RMW_WR;
      RMW_WR:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Mem_read    = 1'b0;
    Mem_write   = 1'b0;
    Mem_address = 32'h0;
    Write_data  = 32'h0;
    if (state == RMW_WR && reset) begin
      Mem_write   = 1'b1;
      Mem_address = rmw_addr_p1;
      Write_data  = rmw_data_p1;
    end else if (do_load || do_sub) begin
      Mem_read    = 1'b1;
      Mem_address = word_addr;
    end else if (do_wstore) begin
      Mem_write   = 1'b1;
      Mem_address = word_addr;
      Write_data  = req_wdata;
    end
  end

  // Stage p1: response registers and RMW latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      err        <= 1'b0;
    end else begin
      resp_valid <= do_load;
      err        <= do_err;
      if (do_load) resp_rdata <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_sub) begin
      rmw_addr_p1 <= word_addr;
      rmw_data_p1 <= merged;
    end
  end

endmodule
